// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential floating-point multiplier with valid/ready handshakes.
//
// Operands are packed {sign, exponent, fraction}. Special operands (NaN, inf,
// zero/denormal) are resolved in the accepting cycle and reported one cycle
// later. Normal operands are multiplied with a one-bit-per-cycle shift-add
// loop, normalised once, and truncated. Denormal inputs act as signed zero.
// Denormal outputs are never produced: small results flush to zero.
//
// Ports:
//   clock      sole clock, rising edge
//   reset      asynchronous, active-high
//   in_valid   operands a/b present
//   in_ready   block can accept operands (IDLE only, low during reset)
//   a, b       operands, W = 1+EXPONENT_BITS+FRACTION_BITS bits
//   out_valid  result/flags valid (DONE only)
//   out_ready  consumer takes the result
//   result     product, W bits
//   flags      {invalid, overflow, underflow, zero}
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for in_valid; operands are classified on accept
// MUL   | shift-add multiply, one multiplier bit per cycle
// NORM  | one-cycle normalise, truncate, overflow/underflow check
// DONE  | result/flags held until out_ready
module fp_mul_seq #(
  parameter int EXPONENT_BITS = 8,
  parameter int FRACTION_BITS = 23
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [EXPONENT_BITS+FRACTION_BITS:0]   a,
  input  logic [EXPONENT_BITS+FRACTION_BITS:0]   b,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [EXPONENT_BITS+FRACTION_BITS:0]   result,
  output logic [3:0]                             flags
);

  localparam int EB = EXPONENT_BITS;
  localparam int FB = FRACTION_BITS;
  localparam int W  = 1 + EB + FB;
  localparam int M  = FB + 1;          // significand width incl. hidden bit
  localparam int PW = 2 * M;           // full product width
  localparam int EW = EB + 2;          // signed exponent working width
  localparam int CW = $clog2(M);       // bit-counter width

  localparam logic signed [EW-1:0] BIAS     = EW'((2 ** (EB - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((2 ** EB) - 1);
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  localparam logic [W-1:0] CANON_NAN = {1'b0, {EB{1'b1}}, 1'b1, {(FB-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic [PW-1:0]          mcand_q, mcand_d;
  logic [M-1:0]           mplier_q, mplier_d;
  logic [PW-1:0]          prod_q, prod_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [W-1:0]           result_q, result_d;
  logic [3:0]             flags_q, flags_d;

  // operand fields and classification
  logic          a_sign, b_sign;
  logic [EB-1:0] a_exp, b_exp;
  logic [FB-1:0] a_frac, b_frac;
  logic          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic          res_sign;
  logic          accept;

  logic signed [EW-1:0] exp_norm;
  logic [FB-1:0]        frac_norm;

  always_comb begin
    a_sign = a[W-1];
    b_sign = b[W-1];
    a_exp  = a[W-2 -: EB];
    b_exp  = b[W-2 -: EB];
    a_frac = a[FB-1:0];
    b_frac = b[FB-1:0];
    // exponent 0 covers both zero and denormal, which are treated alike
    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
    a_inf  = (a_exp == '1) && (a_frac == '0);
    b_inf  = (b_exp == '1) && (b_frac == '0);
    a_nan  = (a_exp == '1) && (a_frac != '0);
    b_nan  = (b_exp == '1) && (b_frac != '0);
    res_sign = a_sign ^ b_sign;
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    flags_d   = flags_q;
    exp_norm  = exp_q;
    frac_norm = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d = res_sign;
          if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            result_d = CANON_NAN;
            flags_d  = 4'b1000;
            state_d  = DONE;
          end else if (a_inf || b_inf) begin
            result_d = {res_sign, {EB{1'b1}}, {FB{1'b0}}};
            flags_d  = 4'b0000;
            state_d  = DONE;
          end else if (a_zero || b_zero) begin
            result_d = {res_sign, {(W-1){1'b0}}};
            flags_d  = 4'b0001;
            state_d  = DONE;
          end else begin
            exp_d    = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS;
            mcand_d  = {{M{1'b0}}, 1'b1, a_frac};
            mplier_d = {1'b1, b_frac};
            prod_d   = '0;
            cnt_d    = CW'(FB);
            state_d  = MUL;
          end
        end
      end

      MUL: begin
        // multiplicand moves left as multiplier bits are consumed LSB first
        if (mplier_q[0]) begin
          prod_d = prod_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == '0) begin
          state_d = NORM;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      NORM: begin
        // product of two [1,2) significands lies in [1,4): at most one shift
        if (prod_q[PW-1]) begin
          exp_norm  = exp_q + EXP_ONE;
          frac_norm = prod_q[PW-2 -: FB];
        end else begin
          exp_norm  = exp_q;
          frac_norm = prod_q[PW-3 -: FB];
        end
        if (exp_norm >= EXP_MAX) begin
          result_d = {sign_q, {EB{1'b1}}, {FB{1'b0}}};
          flags_d  = 4'b0100;
        end else if (exp_norm <= EXP_ZERO) begin
          result_d = {sign_q, {(W-1){1'b0}}};
          flags_d  = 4'b0011;
        end else begin
          result_d = {sign_q, exp_norm[EB-1:0], frac_norm};
          flags_d  = 4'b0000;
        end
        exp_d   = exp_norm;
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: a vector table for single precision, hand
// sequences for DONE back-pressure and mid-operation reset, and a small
// half-precision-style build (5/10).
module tb_fp_mul_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, out_ready;
  logic [31:0] a, b;
  logic        in_ready, out_valid;
  logic [31:0] result;
  logic [3:0]  flags;

  logic        in_valid2, out_ready2;
  logic [15:0] a2, b2;
  logic        in_ready2, out_valid2;
  logic [15:0] result2;
  logic [3:0]  flags2;

  int total = 0;
  int bad   = 0;

  fp_mul_seq #(.EXPONENT_BITS(8), .FRACTION_BITS(23)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  fp_mul_seq #(.EXPONENT_BITS(5), .FRACTION_BITS(10)) dut2 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .result(result2), .flags(flags2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Drives one operation, counts edges from the accepting edge until
  // out_valid is seen, then pops the result.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        output logic [31:0] res, output logic [3:0] flg,
                        output int lat);
    in_valid = 1'b1; a = ia; b = ib;
    @(posedge clock); #1;
    in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    res = result; flg = flags;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op2(input logic [15:0] ia, input logic [15:0] ib,
                         output logic [15:0] res, output logic [3:0] flg,
                         output int lat);
    in_valid2 = 1'b1; a2 = ia; b2 = ib;
    @(posedge clock); #1;
    in_valid2 = 1'b0; a2 = 16'hBEEF; b2 = 16'h1234;
    lat = 1;
    while (!out_valid2 && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    res = result2; flg = flags2;
    out_ready2 = 1'b1;
    @(posedge clock); #1;
    out_ready2 = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  f;
    logic [15:0] r2;
    int          lat;
    int          wait_n;

    vecs.push_back('{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26});
    vecs.push_back('{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, 26});
    vecs.push_back('{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 26});
    vecs.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 26});
    vecs.push_back('{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0000, 26});
    vecs.push_back('{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0100, 26});
    vecs.push_back('{32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000, 26});
    vecs.push_back('{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0100, 26});
    vecs.push_back('{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 26});
    vecs.push_back('{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000, 26});
    vecs.push_back('{32'h80800000, 32'h3F000000, 32'h80000000, 4'b0011, 26});
    vecs.push_back('{32'h00C00000, 32'h3FC00000, 32'h01100000, 4'b0000, 26});
    vecs.push_back('{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1});
    vecs.push_back('{32'h00000001, 32'hFF800000, 32'h7FC00000, 4'b1000, 1});
    vecs.push_back('{32'hFFC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1});
    vecs.push_back('{32'h80400000, 32'h3F800000, 32'h80000000, 4'b0001, 1});
    vecs.push_back('{32'h80000000, 32'hBF800000, 32'h00000000, 4'b0001, 1});
    vecs.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1});
    vecs.push_back('{32'h7F800000, 32'hFF800000, 32'hFF800000, 4'b0000, 1});

    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0;
    reset = 1'b1;
    #1;
    chk("rst_in_ready", 0, 32'(in_ready), 32'd0);
    chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
    chk("rst_result", 0, result, 32'd0);
    chk("rst_flags", 0, 32'(flags), 32'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    chk("post_rst_in_ready", 0, 32'(in_ready), 32'd1);
    chk("post_rst_in_ready2", 0, 32'(in_ready2), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      chk("pre_in_ready", i, 32'(in_ready), 32'd1);
      run_op(vecs[i].a, vecs[i].b, r, f, lat);
      chk("result", i, r, vecs[i].res);
      chk("flags", i, 32'(f), 32'(vecs[i].flg));
      chk("latency", i, lat, vecs[i].lat);
    end

    // back-pressure in DONE: held outputs, no in_ready, in_valid pulse ignored
    in_valid = 1'b1; a = 32'h3FC00000; b = 32'h40000000;
    @(posedge clock); #1;
    in_valid = 1'b0; a = 32'h0; b = 32'h0;
    wait_n = 1;
    while (!out_valid && wait_n < 200) begin
      @(posedge clock); #1;
      wait_n++;
    end
    chk("hold_latency", 0, wait_n, 26);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clock); #1;
      chk("hold_result", i, result, 32'h40400000);
      chk("hold_flags", i, 32'(flags), 32'd0);
      chk("hold_out_valid", i, 32'(out_valid), 32'd1);
      chk("hold_in_ready", i, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("done_cycle_in_ready", 0, 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("release_in_ready", 0, 32'(in_ready), 32'd1);
    chk("release_out_valid", 0, 32'(out_valid), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    chk("no_queue_out_valid", 0, 32'(out_valid), 32'd0);
    chk("no_queue_in_ready", 0, 32'(in_ready), 32'd1);

    // reset during MUL discards the operation
    in_valid = 1'b1; a = 32'h3FC00000; b = 32'h40000000;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("mid_mul_out_valid", 0, 32'(out_valid), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 0, 32'(out_valid), 32'd0);
    chk("mid_rst_result", 0, result, 32'd0);
    chk("mid_rst_flags", 0, 32'(flags), 32'd0);
    chk("mid_rst_in_ready", 0, 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("after_rst_in_ready", 0, 32'(in_ready), 32'd1);
    chk("after_rst_out_valid", 0, 32'(out_valid), 32'd0);
    run_op(32'h3FC00000, 32'h40000000, r, f, lat);
    chk("after_rst_result", 0, r, 32'h40400000);
    chk("after_rst_flags", 0, 32'(f), 32'd0);
    chk("after_rst_latency", 0, lat, 26);

    // 5-bit exponent, 10-bit fraction build
    run_op2(16'h3E00, 16'h4000, r2, f, lat);
    chk("p2_result", 0, 32'(r2), 32'h4200);
    chk("p2_flags", 0, 32'(f), 32'd0);
    chk("p2_latency", 0, lat, 13);
    run_op2(16'h3C00, 16'h3C00, r2, f, lat);
    chk("p2_result", 1, 32'(r2), 32'h3C00);
    chk("p2_latency", 1, lat, 13);
    run_op2(16'h7800, 16'h7800, r2, f, lat);
    chk("p2_result", 2, 32'(r2), 32'h7C00);
    chk("p2_flags", 2, 32'(f), 32'b0100);
    run_op2(16'h7C00, 16'h0000, r2, f, lat);
    chk("p2_result", 3, 32'(r2), 32'h7E00);
    chk("p2_latency", 3, lat, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
